ddram_fill: RTL and testbench

DDRAM_FILL -- requirements
Module: ddram_fill

---
 rtl/ddram_fill.sv | 162 ++++++++++++++++
 tb/tb_ddram_fill.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddram_fill.sv
// ddram_fill: paced DDR3 region fill engine.
// Writes a 64-bit pattern over [BASE, BASE+WORDS) in fixed-length Avalon
// write bursts. Each burst is released by one credit taken from the
// upstream step strobe, so the fill rate follows the upstream counter.
module ddram_fill #(
  parameter int          BURST = 8,
  parameter logic [28:0] BASE  = 29'h0600_0000,
  parameter logic [28:0] WORDS = 29'h0020_0000
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        start,
  input  logic        step,
  input  logic [63:0] pattern,
  input  logic        DDRAM_BUSY,
  output logic [28:0] DDRAM_ADDR,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  output logic        DDRAM_WE,
  output logic        DDRAM_RD,
  output logic        active,
  output logic        done
);

  // End address wraps modulo 2^29 like the rest of the address arithmetic.
  localparam logic [28:0] END_ADDR   = BASE + WORDS;
  localparam logic [28:0] BURST_STEP = 29'(BURST);
  localparam logic [7:0]  BEAT_LAST  = 8'(BURST - 1);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_WAIT_CREDIT = 2'd1,
    S_BURST       = 2'd2,
    S_DONE        = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [3:0]  r_credit;
  logic [7:0]  r_beat;
  logic [28:0] r_cur_addr;
  logic [28:0] r_addr;
  logic [63:0] r_din;
  logic        r_we;

  logic        w_start_ok;
  logic        w_consume;
  logic        w_accept;
  logic        w_last;
  logic [28:0] w_next_addr;

  // start only counts when no pass is running; a burst is released when
  // a credit is waiting; a beat moves when the slave is not stalling.
  assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_consume   = (r_state == S_WAIT_CREDIT) && (r_credit != 4'd0);
  assign w_accept    = (r_state == S_BURST) && r_we && !DDRAM_BUSY;
  assign w_last      = w_accept && (r_beat == BEAT_LAST);
  assign w_next_addr = r_cur_addr + BURST_STEP;

  // State register.
  always_ff @(posedge clk_sys) begin
    if (!RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_next = S_WAIT_CREDIT;
        end
      end
      S_WAIT_CREDIT: begin
        if (r_credit != 4'd0) begin
          w_state_next = S_BURST;
        end
      end
      S_BURST: begin
        if (w_last) begin
          w_state_next = (w_next_addr == END_ADDR) ? S_DONE : S_WAIT_CREDIT;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    active = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_WAIT_CREDIT, S_BURST: active = 1'b1;
      S_DONE:                 done   = 1'b1;
      default: begin
        active = 1'b0;
        done   = 1'b0;
      end
    endcase
  end

  // Credit counter: saturating up on step, down when a burst is released;
  // both on the same cycle cancel out. Runs in every state.
  always_ff @(posedge clk_sys) begin
    if (!RESET) begin
      r_credit <= 4'd0;
    end else if (step && w_consume) begin
      r_credit <= r_credit;
    end else if (step) begin
      if (r_credit != 4'hF) begin
        r_credit <= r_credit + 4'd1;
      end
    end else if (w_consume) begin
      r_credit <= r_credit - 4'd1;
    end
  end

  // Burst datapath: address/data are captured once per burst and held
  // (including through waitrequest) until the last beat is accepted.
  always_ff @(posedge clk_sys) begin
    if (!RESET) begin
      r_cur_addr <= BASE;
      r_beat     <= 8'd0;
      r_addr     <= BASE;
      r_din      <= 64'd0;
      r_we       <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_cur_addr <= BASE;
        r_beat     <= 8'd0;
      end
      if (w_consume) begin
        r_addr <= r_cur_addr;
        r_din  <= pattern;
        r_we   <= 1'b1;
      end
      if (w_accept) begin
        if (w_last) begin
          r_beat     <= 8'd0;
          r_we       <= 1'b0;
          r_cur_addr <= w_next_addr;
        end else begin
          r_beat <= r_beat + 8'd1;
        end
      end
    end
  end

  assign DDRAM_ADDR     = r_addr;
  assign DDRAM_DIN      = r_din;
  assign DDRAM_WE       = r_we;
  assign DDRAM_BURSTCNT = 8'(BURST);
  assign DDRAM_BE       = 8'hFF;
  assign DDRAM_RD       = 1'b0;

endmodule

// File: tb/tb_ddram_fill.sv
// tb_ddram_fill: directed + randomized checks of ddram_fill. Two instances
// share stimulus: dut_a fills 16 words, dut_b fills 128 words.
module tb_ddram_fill;

  localparam logic [28:0] BASE = 29'h0600_0000;
  localparam int          BL   = 8;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        RESET, start_a, start_b, step, busy;
  logic [63:0] pattern;

  logic [28:0] addr_a, addr_b;
  logic [7:0]  bcnt_a, bcnt_b, be_a, be_b;
  logic [63:0] din_a, din_b;
  logic        we_a, we_b, rd_a, rd_b, active_a, active_b, done_a, done_b;

  ddram_fill #(.BURST(8), .BASE(BASE), .WORDS(29'd16)) dut_a (
    .clk_sys(clk_sys), .RESET(RESET), .start(start_a), .step(step),
    .pattern(pattern), .DDRAM_BUSY(busy), .DDRAM_ADDR(addr_a),
    .DDRAM_BURSTCNT(bcnt_a), .DDRAM_DIN(din_a), .DDRAM_BE(be_a),
    .DDRAM_WE(we_a), .DDRAM_RD(rd_a), .active(active_a), .done(done_a)
  );

  ddram_fill #(.BURST(8), .BASE(BASE), .WORDS(29'd128)) dut_b (
    .clk_sys(clk_sys), .RESET(RESET), .start(start_b), .step(step),
    .pattern(pattern), .DDRAM_BUSY(busy), .DDRAM_ADDR(addr_b),
    .DDRAM_BURSTCNT(bcnt_b), .DDRAM_DIN(din_b), .DDRAM_BE(be_b),
    .DDRAM_WE(we_b), .DDRAM_RD(rd_b), .active(active_b), .done(done_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Accepted beats as seen by an Avalon slave.
  logic [28:0] qa_addr[$], qb_addr[$];
  logic [63:0] qa_data[$], qb_data[$];
  int          qa_cyc[$],  qb_cyc[$];

  // Reference model output: expected beat stream of one pass.
  logic [28:0] exp_addr[$];
  logic [63:0] exp_data[$];

  always @(negedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (RESET && we_a && !busy) begin
      qa_addr.push_back(addr_a);
      qa_data.push_back(din_a);
      qa_cyc.push_back(cyc);
    end
    if (RESET && we_b && !busy) begin
      qb_addr.push_back(addr_b);
      qb_data.push_back(din_b);
      qb_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic sample();
    @(negedge clk_sys);
  endtask

  function automatic int nbeats(input bit use_b, input int i0);
    return (use_b ? qb_addr.size() : qa_addr.size()) - i0;
  endfunction

  task automatic wait_beats(input bit use_b, input int i0, input int target, input int maxc);
    int c = 0;
    while (nbeats(use_b, i0) < target && c < maxc) begin
      tick();
      c++;
    end
    chk($sformatf("beats_reached_%0d", target), 64'(nbeats(use_b, i0)), 64'(target));
  endtask

  // Burst b of a pass covers words BASE+b*BL .. +BL-1, all carrying d.
  task automatic expect_burst(input int b, input logic [63:0] d);
    repeat (BL) begin
      exp_addr.push_back(BASE + 29'(b * BL));
      exp_data.push_back(d);
    end
  endtask

  task automatic compare_pass(input string tag, input bit use_b, input int i0);
    int n = nbeats(use_b, i0);
    chk({tag, "_count"}, 64'(n), 64'(exp_addr.size()));
    for (int k = 0; k < exp_addr.size() && k < n; k++) begin
      chk($sformatf("%s_addr%0d", tag, k), 64'(use_b ? qb_addr[i0+k] : qa_addr[i0+k]), 64'(exp_addr[k]));
      chk($sformatf("%s_data%0d", tag, k), use_b ? qb_data[i0+k] : qa_data[i0+k], exp_data[k]);
    end
    exp_addr.delete();
    exp_data.delete();
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    start_a = 1'b0; start_b = 1'b0; step = 1'b0; busy = 1'b0;
    tick(2);
    RESET = 1'b1;
    tick(1);
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1; tick(); start_a = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1; tick(); step = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] p0, p1;
    int i0, r1, r2, c;

    RESET = 1'b0; start_a = 1'b0; start_b = 1'b0; step = 1'b0;
    busy = 1'b0; pattern = 64'd0;
    tick();

    // Reset values, with start/step pulses during reset that must be ignored.
    start_a = 1'b1; start_b = 1'b1; step = 1'b1;
    tick();
    start_a = 1'b0; start_b = 1'b0; step = 1'b0;
    sample();
    chk("rst_we", 64'(we_a), 64'd0);
    chk("rst_active", 64'(active_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_addr", 64'(addr_a), 64'(BASE));
    chk("rst_din", din_a, 64'd0);
    chk("burstcnt", 64'(bcnt_a), 64'd8);
    chk("be", 64'(be_a), 64'hFF);
    chk("rd", 64'(rd_a), 64'd0);
    tick();
    RESET = 1'b1;
    tick(5);
    chk("rst_start_ignored", 64'(active_a), 64'd0);

    // Start with no credit: waits with WE low; one step releases a burst.
    i0 = qa_addr.size();
    p0 = {$urandom(), $urandom()};
    p1 = {$urandom(), $urandom()};
    pattern = p0;
    pulse_start_a();
    tick(6);
    sample();
    chk("nocredit_active", 64'(active_a), 64'd1);
    chk("nocredit_we", 64'(we_a), 64'd0);
    chk("nocredit_beats", 64'(nbeats(0, i0)), 64'd0);
    tick();
    pulse_step();
    sample();
    sample();
    chk("step_to_we_2cyc", 64'(we_a), 64'd1);
    chk("first_addr", 64'(addr_a), 64'(BASE));
    tick();
    pattern = {$urandom(), $urandom()};
    pulse_start_a();
    wait_beats(0, i0, 8, 50);
    sample();
    chk("between_active", 64'(active_a), 64'd1);
    chk("between_done", 64'(done_a), 64'd0);
    chk("between_we", 64'(we_a), 64'd0);
    tick();
    pattern = p1;
    pulse_step();
    wait_beats(0, i0, 16, 50);
    sample();
    chk("pass1_done", 64'(done_a), 64'd1);
    chk("pass1_inactive", 64'(active_a), 64'd0);
    chk("pass1_we", 64'(we_a), 64'd0);
    expect_burst(0, p0);
    expect_burst(1, p1);
    compare_pass("pass1", 0, i0);
    tick();

    // Start then two step pulses, BUSY low: 16 beats, done right after.
    do_reset();
    i0 = qa_addr.size();
    p0 = {$urandom(), $urandom()};
    pattern = p0;
    pulse_start_a();
    pulse_step();
    tick();
    pulse_step();
    wait_beats(0, i0, 16, 60);
    sample();
    chk("pass2_done", 64'(done_a), 64'd1);
    expect_burst(0, p0);
    expect_burst(1, p0);
    compare_pass("pass2", 0, i0);
    tick();

    // Random waitrequest with two randomly timed steps.
    do_reset();
    i0 = qa_addr.size();
    p0 = {$urandom(), $urandom()};
    pattern = p0;
    r1 = int'($urandom_range(1, 10));
    r2 = int'($urandom_range(12, 40));
    pulse_start_a();
    c = 0;
    while (nbeats(0, i0) < 16 && c < 400) begin
      busy = ($urandom_range(0, 3) == 0);
      step = (c == r1) || (c == r2);
      tick();
      c++;
    end
    busy = 1'b0;
    step = 1'b0;
    sample();
    chk("randbusy_done", 64'(done_a), 64'd1);
    expect_burst(0, p0);
    expect_burst(1, p0);
    compare_pass("randbusy", 0, i0);
    tick();

    // Waitrequest held for 5 cycles on beat 3: outputs hold, 8 beats total.
    do_reset();
    i0 = qa_addr.size();
    p0 = {$urandom(), $urandom()};
    pattern = p0;
    pulse_start_a();
    pulse_step();
    wait_beats(0, i0, 3, 40);
    busy = 1'b1;
    pattern = ~p0;
    for (int k = 0; k < 5; k++) begin
      sample();
      chk($sformatf("busy_we_%0d", k), 64'(we_a), 64'd1);
      chk($sformatf("busy_addr_%0d", k), 64'(addr_a), 64'(BASE));
      chk($sformatf("busy_din_%0d", k), din_a, p0);
      tick();
    end
    busy = 1'b0;
    chk("busy_beats_held", 64'(nbeats(0, i0)), 64'd3);
    wait_beats(0, i0, 8, 40);
    tick(3);
    expect_burst(0, p0);
    compare_pass("busy", 0, i0);

    // Reset during beat 4 aborts; a new start then runs a clean pass.
    do_reset();
    i0 = qa_addr.size();
    pattern = {$urandom(), $urandom()};
    pulse_start_a();
    pulse_step();
    wait_beats(0, i0, 4, 40);
    RESET = 1'b0;
    sample();
    sample();
    chk("abort_we", 64'(we_a), 64'd0);
    chk("abort_active", 64'(active_a), 64'd0);
    chk("abort_addr", 64'(addr_a), 64'(BASE));
    tick();
    RESET = 1'b1;
    tick(10);
    chk("abort_no_more_beats", 64'(nbeats(0, i0)), 64'd4);
    chk("abort_we_idle", 64'(we_a), 64'd0);
    i0 = qa_addr.size();
    p0 = {$urandom(), $urandom()};
    pattern = p0;
    pulse_start_a();
    pulse_step();
    pulse_step();
    wait_beats(0, i0, 16, 60);
    sample();
    chk("restart_done", 64'(done_a), 64'd1);
    expect_burst(0, p0);
    expect_burst(1, p0);
    compare_pass("restart", 0, i0);
    tick();

    // 20 steps while idle saturate at 15 credits: 15 bursts, then a stall.
    do_reset();
    i0 = qb_addr.size();
    p0 = {$urandom(), $urandom()};
    pattern = p0;
    step = 1'b1;
    tick(20);
    step = 1'b0;
    start_b = 1'b1; tick(); start_b = 1'b0;
    wait_beats(1, i0, 120, 400);
    tick(20);
    chk("sat_stall_beats", 64'(nbeats(1, i0)), 64'd120);
    chk("sat_stall_active", 64'(active_b), 64'd1);
    chk("sat_stall_we", 64'(we_b), 64'd0);
    chk("sat_stall_done", 64'(done_b), 64'd0);
    pulse_step();
    wait_beats(1, i0, 128, 40);
    sample();
    chk("sat_done", 64'(done_b), 64'd1);
    for (int b = 0; b < 16; b++) expect_burst(b, p0);
    compare_pass("sat", 1, i0);
    tick();

    // Step coincident with consume at credit 1: credit stays 1, so exactly
    // two bursts run back to back and then the engine waits.
    do_reset();
    i0 = qb_addr.size();
    p0 = {$urandom(), $urandom()};
    pattern = p0;
    start_b = 1'b1; tick(); start_b = 1'b0;
    tick(3);
    step = 1'b1;
    tick(2);
    step = 1'b0;
    wait_beats(1, i0, 16, 60);
    tick(20);
    chk("coinc_beats", 64'(nbeats(1, i0)), 64'd16);
    if (nbeats(1, i0) >= 9) begin
      chk("coinc_gap", 64'(qb_cyc[i0+8] - qb_cyc[i0+7]), 64'd2);
    end
    chk("coinc_active", 64'(active_b), 64'd1);
    expect_burst(0, p0);
    expect_burst(1, p0);
    compare_pass("coinc", 1, i0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
